bitwise_slice_unit: RTL

Parametrised, sequential successor to the fixed 16-bit elementary bitwise gates. It evaluates one of eight bitwise operations on two WIDTH-bit operands, SLICE bits per clock, through a single reusable slice datapath. It sits between operand registers and the ALU result path, and uses a valid/ready handshake on both sides. Result flags (zero, all-ones) are produced with the result.

---
 rtl/logic_ops_pkg.sv | 23 ++
 rtl/slice_logic.sv | 29 ++
 rtl/bitwise_slice_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/logic_ops_pkg.sv
// Shared constants for the sliced bitwise unit: operation codes, FSM state
// encodings and a counter-width helper.
package logic_ops_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    // Slice counter never narrower than one bit, even for a single slice.
    function automatic int cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/slice_logic.sv
// Combinational N-bit bitwise operator: one slice of the shared datapath.
module slice_logic
    import logic_ops_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] a_s,
    input  logic [N-1:0] b_s,
    output logic [N-1:0] y_s
);

    // Elementary gate selection; NOT A and PASS A ignore b_s.
    always_comb begin
        y_s = '0;
        case (op)
            OP_AND:  y_s = a_s & b_s;
            OP_OR:   y_s = a_s | b_s;
            OP_XOR:  y_s = a_s ^ b_s;
            OP_NAND: y_s = ~(a_s & b_s);
            OP_NOR:  y_s = ~(a_s | b_s);
            OP_XNOR: y_s = ~(a_s ^ b_s);
            OP_NOTA: y_s = ~a_s;
            OP_PASS: y_s = a_s;
            default: y_s = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_slice_unit.sv
// Sequential bitwise unit: evaluates one of eight operations SLICE bits per
// clock through a single slice_logic instance, with valid/ready on both sides.
module bitwise_slice_unit
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = cnt_width(NSLICE);
    localparam logic [CW-1:0] CNT_LAST = CW'(NSLICE - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic             ld_s;
    logic [SLICE-1:0] a_sl_s, b_sl_s, y_sl_s;

    assign a_sl_s = a_q[cnt_q*SLICE +: SLICE];
    assign b_sl_s = b_q[cnt_q*SLICE +: SLICE];

    slice_logic #(.N(SLICE)) u_slice (
        .op  (op_q),
        .a_s (a_sl_s),
        .b_s (b_sl_s),
        .y_s (y_sl_s)
    );

    // Next-state, counter, accumulator and result/flag update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        y_d     = y_q;
        zero_d  = zero_q;
        ones_d  = ones_q;
        ld_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ld_s    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d[cnt_q*SLICE +: SLICE] = y_sl_s;
                // The last slice is merged combinationally so y sees the whole word.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    y_d     = acc_d;
                    zero_d  = (acc_d == '0);
                    ones_d  = (acc_d == '1);
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            zero_q  <= 1'b1;
            ones_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            ones_q  <= ones_d;
        end
    end

    // Operand latches, written only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= 3'b000;
            a_q  <= '0;
            b_q  <= '0;
        end else if (ld_s) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
        end else begin
            op_q <= op_q;
            a_q  <= a_q;
            b_q  <= b_q;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_HOLD);
    assign y         = y_q;
    assign zero      = zero_q;
    assign ones      = ones_q;

endmodule
